// File: rtl/core_pkg.sv
// Shared core constants and types for the integer register file.
package core_pkg;

  localparam int XLEN  = 32;
  localparam int NREGS = 32;
  localparam int AW    = $clog2(NREGS);

  typedef logic [AW-1:0]   reg_addr_t;
  typedef logic [XLEN-1:0] xdata_t;

endpackage

// File: rtl/regfile_scoreboard.sv
// Busy scoreboard: one bit per register with an outstanding late (wr1) write.
module regfile_scoreboard #(
  parameter int NREGS  = core_pkg::NREGS,
  parameter int AW     = $clog2(NREGS),
  parameter bit BYPASS = 1'b1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [AW-1:0] rd_addr_a,
  input  logic [AW-1:0] rd_addr_b,
  input  logic          wr1_en,
  input  logic [AW-1:0] wr1_addr,
  input  logic          rsv_en,
  input  logic [AW-1:0] rsv_addr,
  output logic          busy_a,
  output logic          busy_b
);

  logic [NREGS-1:0] busy_q;
  logic [NREGS-1:0] busy_d;

  // NOTE: every combinational output gets a default first so no path leaves it unassigned (no latch).
  always_comb begin
    busy_d = busy_q;
    if (wr1_en) busy_d[wr1_addr] = 1'b0;
    // A new reservation on the retiring register supersedes the clear.
    if (rsv_en) busy_d[rsv_addr] = 1'b1;
    busy_d[0] = 1'b0;
  end

  // NOTE: sequential state uses non-blocking assignments so all flops update together at the edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) busy_q <= '0;
    else     busy_q <= busy_d;
  end

  function automatic logic lookup(input logic [NREGS-1:0] busy,
                                  input logic [AW-1:0]    addr,
                                  input logic             w1_en,
                                  input logic [AW-1:0]    w1_addr,
                                  input logic             r_en,
                                  input logic [AW-1:0]    r_addr);
    logic releasing;
    releasing = BYPASS && w1_en && (w1_addr == addr) && !(r_en && (r_addr == addr));
    return busy[addr] && !releasing;
  endfunction

  always_comb begin
    busy_a = 1'b0;
    busy_b = 1'b0;
    if (!rst) begin
      busy_a = lookup(busy_q, rd_addr_a, wr1_en, wr1_addr, rsv_en, rsv_addr);
      busy_b = lookup(busy_q, rd_addr_b, wr1_en, wr1_addr, rsv_en, rsv_addr);
    end
  end

endmodule

// File: rtl/regfile_mp.sv
// Integer register file: 2 combinational read ports, 2 write ports (wr1 wins),
// optional write-to-read bypass and an integrated late-write busy scoreboard.
module regfile_mp #(
  parameter int XLEN   = core_pkg::XLEN,
  parameter int NREGS  = core_pkg::NREGS,
  parameter bit BYPASS = 1'b1,
  localparam int AW    = $clog2(NREGS)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [AW-1:0]   rd_addr_a,
  input  logic [AW-1:0]   rd_addr_b,
  output logic [XLEN-1:0] rd_data_a,
  output logic [XLEN-1:0] rd_data_b,
  output logic            busy_a,
  output logic            busy_b,
  input  logic            wr0_en,
  input  logic [AW-1:0]   wr0_addr,
  input  logic [XLEN-1:0] wr0_data,
  input  logic            wr1_en,
  input  logic [AW-1:0]   wr1_addr,
  input  logic [XLEN-1:0] wr1_data,
  input  logic            rsv_en,
  input  logic [AW-1:0]   rsv_addr
);

  if (NREGS < 2 || (1 << AW) != NREGS) begin : g_bad_nregs
    $error("regfile_mp: NREGS must be a power of 2 and at least 2");
  end

  logic [XLEN-1:0] regs_q [NREGS];
  logic [XLEN-1:0] regs_d [NREGS];

  always_comb begin
    regs_d = regs_q;
    if (wr0_en) regs_d[wr0_addr] = wr0_data;
    if (wr1_en) regs_d[wr1_addr] = wr1_data;
    regs_d[0] = '0;
  end

  // NOTE: the storage array is reset because reads after reset must return 0, not X.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NREGS; i++) regs_q[i] <= '0;
    end else begin
      regs_q <= regs_d;
    end
  end

  function automatic logic [XLEN-1:0] read_mux(input logic [AW-1:0]   addr,
                                               input logic [XLEN-1:0] stored,
                                               input logic            w0_en,
                                               input logic [AW-1:0]   w0_addr,
                                               input logic [XLEN-1:0] w0_data,
                                               input logic            w1_en,
                                               input logic [AW-1:0]   w1_addr,
                                               input logic [XLEN-1:0] w1_data);
    if (addr == '0)                                return '0;
    else if (BYPASS && w1_en && w1_addr == addr)   return w1_data;
    else if (BYPASS && w0_en && w0_addr == addr)   return w0_data;
    else                                           return stored;
  endfunction

  // Gated by rst so bypassed write data cannot leak out while reset is held.
  always_comb begin
    rd_data_a = '0;
    rd_data_b = '0;
    if (!rst) begin
      rd_data_a = read_mux(rd_addr_a, regs_q[rd_addr_a], wr0_en, wr0_addr, wr0_data,
                           wr1_en, wr1_addr, wr1_data);
      rd_data_b = read_mux(rd_addr_b, regs_q[rd_addr_b], wr0_en, wr0_addr, wr0_data,
                           wr1_en, wr1_addr, wr1_data);
    end
  end

  regfile_scoreboard #(
    .NREGS  (NREGS),
    .AW     (AW),
    .BYPASS (BYPASS)
  ) u_scoreboard (
    .clk       (clk),
    .rst       (rst),
    .rd_addr_a (rd_addr_a),
    .rd_addr_b (rd_addr_b),
    .wr1_en    (wr1_en),
    .wr1_addr  (wr1_addr),
    .rsv_en    (rsv_en),
    .rsv_addr  (rsv_addr),
    .busy_a    (busy_a),
    .busy_b    (busy_b)
  );

endmodule

// File: tb/tb_regfile_mp.sv
// Directed self-checking bench for regfile_mp with BYPASS=1.
module tb_regfile_mp;

  localparam int XLEN  = 32;
  localparam int NREGS = 32;
  localparam int AW    = 5;

  logic            clk;
  logic            rst;
  logic [AW-1:0]   rd_addr_a, rd_addr_b;
  logic [XLEN-1:0] rd_data_a, rd_data_b;
  logic            busy_a, busy_b;
  logic            wr0_en, wr1_en, rsv_en;
  logic [AW-1:0]   wr0_addr, wr1_addr, rsv_addr;
  logic [XLEN-1:0] wr0_data, wr1_data;

  int n_checks = 0;
  int n_pass   = 0;

  regfile_mp #(.XLEN(XLEN), .NREGS(NREGS), .BYPASS(1'b1)) dut (
    .clk       (clk),
    .rst       (rst),
    .rd_addr_a (rd_addr_a),
    .rd_addr_b (rd_addr_b),
    .rd_data_a (rd_data_a),
    .rd_data_b (rd_data_b),
    .busy_a    (busy_a),
    .busy_b    (busy_b),
    .wr0_en    (wr0_en),
    .wr0_addr  (wr0_addr),
    .wr0_data  (wr0_data),
    .wr1_en    (wr1_en),
    .wr1_addr  (wr1_addr),
    .wr1_data  (wr1_data),
    .rsv_en    (rsv_en),
    .rsv_addr  (rsv_addr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [XLEN-1:0] got, input logic [XLEN-1:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
  endtask

  // Inputs change on the falling edge; outputs are sampled 2 ns later, well before the rising edge.
  task automatic cycle();
    @(negedge clk);
    wr0_en = 1'b0; wr1_en = 1'b0; rsv_en = 1'b0;
  endtask

  task automatic settle();
    #2;
  endtask

  initial begin
    rst = 1'b1;
    rd_addr_a = '0; rd_addr_b = '0;
    wr0_en = 1'b0; wr0_addr = '0; wr0_data = '0;
    wr1_en = 1'b0; wr1_addr = '0; wr1_data = '0;
    rsv_en = 1'b0; rsv_addr = '0;

    // Reset state
    cycle(); rd_addr_a = 5'd5; rd_addr_b = 5'd3; settle();
    check("reset_rd_a", rd_data_a, 32'h0);
    check("reset_busy_b", {31'b0, busy_b}, 32'h0);
    rst = 1'b0;

    // Preload x5, reserve x3, then async reset mid-cycle
    cycle(); wr0_en = 1'b1; wr0_addr = 5'd5; wr0_data = 32'h1234_5678;
    rsv_en = 1'b1; rsv_addr = 5'd3;
    cycle(); settle();
    check("preload_x5", rd_data_a, 32'h1234_5678);
    check("preload_busy3", {31'b0, busy_b}, 32'h1);
    rst = 1'b1; #1;
    check("async_rst_rd_a", rd_data_a, 32'h0);
    check("async_rst_busy_b", {31'b0, busy_b}, 32'h0);
    rst = 1'b0; #1;
    check("post_rst_x5", rd_data_a, 32'h0);
    check("post_rst_busy3", {31'b0, busy_b}, 32'h0);

    // Same-cycle bypass of wr0
    cycle(); wr0_en = 1'b1; wr0_addr = 5'd5; wr0_data = 32'hDEAD_BEEF; rd_addr_a = 5'd5; settle();
    check("bypass_wr0_x5", rd_data_a, 32'hDEAD_BEEF);
    cycle(); settle();
    check("stored_x5", rd_data_a, 32'hDEAD_BEEF);

    // x0 guard
    cycle(); wr0_en = 1'b1; wr0_addr = 5'd0; wr0_data = 32'hFFFF_FFFF;
    wr1_en = 1'b1; wr1_addr = 5'd0; wr1_data = 32'hFFFF_FFFF;
    rsv_en = 1'b1; rsv_addr = 5'd0; rd_addr_a = 5'd0; settle();
    check("x0_bypass", rd_data_a, 32'h0);
    cycle(); settle();
    check("x0_stored", rd_data_a, 32'h0);
    check("x0_busy", {31'b0, busy_a}, 32'h0);

    // Write collisions
    cycle(); wr0_en = 1'b1; wr0_addr = 5'd7; wr0_data = 32'h11;
    wr1_en = 1'b1; wr1_addr = 5'd7; wr1_data = 32'h22; rd_addr_a = 5'd7; settle();
    check("collide_bypass_x7", rd_data_a, 32'h22);
    cycle(); settle();
    check("collide_stored_x7", rd_data_a, 32'h22);
    wr0_en = 1'b1; wr0_addr = 5'd8; wr0_data = 32'h33;
    wr1_en = 1'b1; wr1_addr = 5'd9; wr1_data = 32'h44;
    cycle(); rd_addr_a = 5'd8; rd_addr_b = 5'd9; settle();
    check("dual_x8", rd_data_a, 32'h33);
    check("dual_x9", rd_data_b, 32'h44);

    // Scoreboard set / release
    cycle(); rsv_en = 1'b1; rsv_addr = 5'd10; rd_addr_a = 5'd10; settle();
    check("rsv10_same_cycle", {31'b0, busy_a}, 32'h0);
    cycle(); settle();
    check("rsv10_busy", {31'b0, busy_a}, 32'h1);
    wr1_en = 1'b1; wr1_addr = 5'd10; wr1_data = 32'h55; #1;
    check("wr1_x10_busy_fwd", {31'b0, busy_a}, 32'h0);
    check("wr1_x10_data_fwd", rd_data_a, 32'h55);
    cycle(); settle();
    check("x10_busy_after", {31'b0, busy_a}, 32'h0);
    check("x10_stored", rd_data_a, 32'h55);

    // Reserve and release on the same register in one cycle
    cycle(); rsv_en = 1'b1; rsv_addr = 5'd12;
    wr1_en = 1'b1; wr1_addr = 5'd12; wr1_data = 32'h66; rd_addr_b = 5'd12;
    cycle(); settle();
    check("rsv_wr1_x12_busy", {31'b0, busy_b}, 32'h1);
    check("rsv_wr1_x12_data", rd_data_b, 32'h66);
    wr1_en = 1'b1; wr1_addr = 5'd12; wr1_data = 32'h77;
    cycle(); settle();
    check("x12_released", {31'b0, busy_b}, 32'h0);
    check("x12_stored", rd_data_b, 32'h77);

    // wr0 does not touch busy
    rsv_en = 1'b1; rsv_addr = 5'd13;
    cycle(); wr0_en = 1'b1; wr0_addr = 5'd13; wr0_data = 32'h88; rd_addr_a = 5'd13;
    cycle(); settle();
    check("wr0_keeps_busy13", {31'b0, busy_a}, 32'h1);
    check("x13_stored", rd_data_a, 32'h88);

    // Reset held across an edge loses the in-flight write and clears busy
    wr0_en = 1'b1; wr0_addr = 5'd14; wr0_data = 32'hAA; rd_addr_b = 5'd14;
    rst = 1'b1; #1;
    check("rst_gates_bypass", rd_data_b, 32'h0);
    cycle(); rst = 1'b0; settle();
    check("inflight_x14_lost", rd_data_b, 32'h0);
    check("busy13_cleared", {31'b0, busy_a}, 32'h0);
    check("x13_cleared", rd_data_a, 32'h0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
